rchan_receiver: RTL

Synchronous receiver for the right-hand 4-phase bundled-data channel of the resilient pipeline stage controller. It turns the controller's `Rreq`/`Rack` handshake into a clocked valid/ready stream. The block synchronises the request, captures the bundled data into a small FIFO and returns the acknowledge. It sits at the boundary where the self-timed resilient pipeline hands results to the clocked test or consumer logic.

---
 rtl/rchan_receiver_pkg.sv | 13 +
 rtl/rchan_fifo.sv | 50 +++++
 rtl/rchan_receiver.sv | 106 ++++++++++
 3 files changed

// File: rtl/rchan_receiver_pkg.sv
// rtl/rchan_receiver_pkg.sv - shared types and constants for the right-channel receiver
package rchan_receiver_pkg;

  typedef enum logic [1:0] {
    REARM = 2'd0,
    IDLE  = 2'd1,
    ACKED = 2'd2
  } rstate_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int TOK_W           = 16;

endpackage

// File: rtl/rchan_fifo.sv
// rtl/rchan_fifo.sv - synchronous FIFO with registered head entry and valid flag
module rchan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [AW:0]      count, count_after_pop;

  assign full            = (count == (AW+1)'(DEPTH));
  assign empty           = (count == '0);
  assign rd_next         = rd_ptr + AW'(pop);
  assign count_after_pop = count - (AW+1)'(pop);

  // Head and valid look only at entries already in memory, so a push is
  // visible one edge after it lands; a pop advances the head on its own edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_after_pop + (AW+1)'(push);
      valid  <= (count_after_pop != '0);
      if (count_after_pop != '0) head <= mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rchan_receiver.sv
// rtl/rchan_receiver.sv - 4-phase bundled-data receiver turning Rreq/Rack into a valid/ready stream
module rchan_receiver
  import rchan_receiver_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TOK_W-1:0] tok_count
);

  logic [SYNC_STAGES-1:0] sync_q, prime_q;
  logic                   req_s, primed;
  rstate_t                state, state_nx;
  logic                   push, pop, fifo_full, fifo_empty;
  logic [TOK_W-1:0]       tok_q;

  // prime_q fills alongside the synchroniser so REARM ignores the reset
  // value of req_s and waits for a genuinely sampled low request.
  genvar i;
  generate
    for (i = 0; i < SYNC_STAGES; i++) begin : g_sync
      if (i == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sync_q[0]  <= 1'b0;
            prime_q[0] <= 1'b0;
          end else begin
            sync_q[0]  <= req;
            prime_q[0] <= 1'b1;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sync_q[i]  <= 1'b0;
            prime_q[i] <= 1'b0;
          end else begin
            sync_q[i]  <= sync_q[i-1];
            prime_q[i] <= prime_q[i-1];
          end
        end
      end
    end
  endgenerate

  assign req_s  = sync_q[SYNC_STAGES-1];
  assign primed = prime_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= REARM;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      REARM:   if (primed && !req_s)     state_nx = IDLE;
      IDLE:    if (req_s && !fifo_full)  state_nx = ACKED;
      ACKED:   if (!req_s)               state_nx = IDLE;
      default:                           state_nx = REARM;
    endcase
  end

  always_comb begin
    push = 1'b0;
    if (state == IDLE && req_s && !fifo_full) push = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack   <= 1'b0;
      tok_q <= '0;
    end else begin
      ack   <= (state_nx == ACKED);
      tok_q <= tok_q + TOK_W'(push);
    end
  end

  assign pop       = out_valid && out_ready && !fifo_empty;
  assign tok_count = tok_q;

  rchan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .valid (out_valid),
    .head  (out_data)
  );

endmodule
